conv_relu_pool22: RTL and testbench
===================================

Name: conv_relu_pool22

Overview:
- Downstream stage of the 4-channel 5x5 convolution unit.
- Consumes one convolution sum per valid cycle, in raster order over an IN_W x IN_H feature map.
- Per pixel: adds the per-map bias, applies optional ReLU, then streams a 2x2 stride-2 max-pool.
- Emits (IN_W/2)*(IN_H/2) pooled values per frame to the next layer, each with a valid strobe and an end-of-frame pulse.

Parameters:
- BIT_WIDTH, 8: width of the bias input.
- OUT_WIDTH, 32: width of convolution sums, internal arithmetic and the pooled output.
- IN_W, 10: input map width in pixels; must be even and >= 2.
- IN_H, 10: input map height in pixels; must be even and >= 2.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data carries a valid convolution sum this cycle.
- in_data  input  OUT_WIDTH  signed convolution sum for the current pixel.
- bias  input  BIT_WIDTH  signed bias; sign-extended and added to every pixel; must be stable for the whole frame.
- out_valid  output  1  registered; pooled value is valid this cycle.
- out_data  output  OUT_WIDTH  registered signed pooled value.
- frame_done  output  1  registered one-cycle pulse, coincident with the last out_valid of a frame.

Behaviour:
- Reset (asynchronous, rst=1):
  - out_valid=0, out_data=0, frame_done=0.
  - Column counter, row counter and horizontal hold register cleared to 0.
  - Line buffer (IN_W/2 entries x OUT_WIDTH) is not cleared; every entry is written on an even row before it is read on the odd row.
- Reset mid-frame: partial frame discarded. The first in_valid after rst deasserts is pixel (0,0).
- in_valid=0 cycles: no state changes, out_valid=0. Gaps of any length are allowed anywhere in a frame.
- Per accepted pixel (row r, column c):
  - s = in_data + sign_extend(bias), OUT_WIDTH bits, two's-complement wrap (no saturation).
  - v = ReLU(s) or s (see Optional Feature).
- Column handling:
  - c even: hold <= v.
  - c odd: h = signed max(hold, v).
- Row handling (c odd only):
  - r even: linebuf[c>>1] <= h.
  - r odd: out_data <= signed max(linebuf[c>>1], h) and out_valid <= 1 on the next clock edge.
  - Latency: one cycle from the accepting edge of pixel (odd r, odd c) to out_valid.
- out_valid is high for exactly one cycle per pooled result; all other cycles it is 0. out_data holds its last value while out_valid=0.
- Counters:
  - c increments per accepted pixel; at IN_W-1 it wraps to 0 and r increments.
  - At r=IN_H-1 and c=IN_W-1, r wraps to 0 and frame_done=1 in the same cycle as that pixel's out_valid.
  - The next frame may start on the very next cycle; there is no idle requirement between frames.
- Signed comparisons throughout. On ties either operand may be chosen, since the values are equal.

Optional Feature:
- Macro: CONV_RELU_POOL_RELU_EN.
- Defined: v = 0 when s < 0, else v = s.
- Undefined: v = s, so negative values pass into the pooling unchanged.
- Timing and latency are identical in both builds.

Test Plan:
- Ramp: IN_W=IN_H=4, bias=0, in_data=0..15 raster, back-to-back.
  - Required: out_data 5,7,13,15 in that order.
  - frame_done high only with 15.
  - Each out_valid one cycle after the inputs 5,7,13,15.
- Negative inputs: all 16 inputs = -5, bias=0.
  - With macro: four outputs of 0.
  - Without macro: four outputs of -5.
- Bias: all inputs 10, bias=8'hFD (-3).
  - Required: four outputs of 7.
  - Repeat with bias=8'h05: four outputs of 15.
- Bubbles: ramp 0..15 with in_valid toggled 1/0 every cycle.
  - Required: values 5,7,13,15 unchanged; each out_valid one cycle after its input.
- Reset mid-frame: feed 6 ramp pixels, pulse rst asynchronously, then a full ramp 0..15.
  - Required: exactly four outputs 5,7,13,15 and a single frame_done.
- Back-to-back frames: two consecutive ramps 0..15, then 100..115, no gap.
  - Required: outputs 5,7,13,15,105,107,113,115.
  - frame_done pulses with 15 and with 115.

Source files
------------

// File: rtl/conv_relu_pool22.sv
// Bias add, optional ReLU (macro CONV_RELU_POOL_RELU_EN) and streaming 2x2 stride-2
// max-pool over a raster-ordered IN_W x IN_H feature map.
module conv_relu_pool22 #(
  parameter int BIT_WIDTH = 8,
  parameter int OUT_WIDTH = 32,
  parameter int IN_W      = 10,
  parameter int IN_H      = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [OUT_WIDTH-1:0] in_data,
  input  logic        [BIT_WIDTH-1:0] bias,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        frame_done
);
  localparam int CW = (IN_W > 2) ? $clog2(IN_W) : 1;
  localparam int RW = (IN_H > 2) ? $clog2(IN_H) : 1;
  localparam int LB = IN_W / 2;
  localparam int LW = (LB > 1) ? $clog2(LB) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [LW-1:0] lidx;
  logic          col_last, row_last;

  logic signed [OUT_WIDTH-1:0] bias_ext, s, v, h, hold, lb_rd, pooled;
  logic signed [OUT_WIDTH-1:0] linebuf [LB];

  assign bias_ext = OUT_WIDTH'($signed(bias));
  assign s        = in_data + bias_ext;

`ifdef CONV_RELU_POOL_RELU_EN
  assign v = s[OUT_WIDTH-1] ? '0 : s;
`else
  assign v = s;
`endif

  // horizontal pair max, then vertical max against the even row's stored pair
  assign h        = (hold > v) ? hold : v;
  assign lidx     = LW'(col >> 1);
  assign lb_rd    = linebuf[lidx];
  assign pooled   = (lb_rd > h) ? lb_rd : h;
  assign col_last = (col == CW'(IN_W - 1));
  assign row_last = (row == RW'(IN_H - 1));

  // line buffer is never reset: each entry is written on an even row before its odd-row read
  always_ff @(posedge clk) begin
    if (in_valid && col[0] && !row[0]) linebuf[lidx] <= h;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (!col[0]) begin
          hold <= v;
        end else if (row[0]) begin
          out_data   <= pooled;
          out_valid  <= 1'b1;
          frame_done <= col_last && row_last;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_relu_pool22.sv
// Randomized and directed bench for conv_relu_pool22 on a 4x4 map, against a frame-array model.
module tb_conv_relu_pool22;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int BW = 8;
  localparam int OW = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [OW-1:0] in_data;
  logic        [BW-1:0] bias;
  logic                 out_valid;
  logic signed [OW-1:0] out_data;
  logic                 frame_done;

  int checks = 0;
  int errors = 0;
  int mr, mc, last_d, fds;
  int pix [H][W];
  int got [$];
  int exp8 [8];

  conv_relu_pool22 #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .IN_W(W), .IN_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .bias(bias),
    .out_valid(out_valid), .out_data(out_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int act(input int x);
`ifdef CONV_RELU_POOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // one clock cycle: drive, update the frame model, then check all outputs
  task automatic step(input bit v, input int d, input int b);
    bit ev, efd;
    int ed;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    bias     = b[BW-1:0];
    ev = 1'b0; efd = 1'b0; ed = last_d;
    if (v) begin
      pix[mr][mc] = act(d + b);
      if (mr % 2 == 1 && mc % 2 == 1) begin
        ev  = 1'b1;
        ed  = imax(imax(pix[mr-1][mc-1], pix[mr-1][mc]), imax(pix[mr][mc-1], pix[mr][mc]));
        efd = (mr == H - 1) && (mc == W - 1);
      end
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", longint'(out_valid), longint'(ev));
    chk("frame_done", longint'(frame_done), longint'(efd));
    chk("out_data", longint'(out_data), longint'(ed));
    if (out_valid) got.push_back(int'(out_data));
    if (frame_done) fds++;
    last_d = ed;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_data", longint'(out_data), 0);
    chk("rst_fd", longint'(frame_done), 0);
    mr = 0; mc = 0; last_d = 0; fds = 0;
    got.delete();
  endtask

  task automatic clear_log();
    got.delete();
    fds = 0;
  endtask

  task automatic ramp(input int base, input int b, input bit bubbles);
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, base + i, b);
      if (bubbles) step(1'b0, 0, b);
    end
  endtask

  task automatic check_list(input string tag, input int n, input int nfd);
    chk({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got.size()) chk(tag, got[i], exp8[i]);
    chk({tag, "_frames"}, fds, nfd);
  endtask

  initial begin
    int b, nv;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; bias = '0;
    mr = 0; mc = 0; last_d = 0; fds = 0;
    repeat (2) @(negedge clk);
    chk("reset_valid", longint'(out_valid), 0);
    chk("reset_data", longint'(out_data), 0);
    chk("reset_fd", longint'(frame_done), 0);
    rst = 1'b0;

    // ramp
    clear_log();
    ramp(0, 0, 1'b0);
    exp8 = '{5, 7, 13, 15, 0, 0, 0, 0};
    check_list("ramp", 4, 1);

    // negative inputs
    clear_log();
    for (int i = 0; i < W * H; i++) step(1'b1, -5, 0);
`ifdef CONV_RELU_POOL_RELU_EN
    nv = 0;
`else
    nv = -5;
`endif
    exp8 = '{nv, nv, nv, nv, 0, 0, 0, 0};
    check_list("negative", 4, 1);

    // bias sign extension
    clear_log();
    for (int i = 0; i < W * H; i++) step(1'b1, 10, -3);
    exp8 = '{7, 7, 7, 7, 0, 0, 0, 0};
    check_list("bias_neg", 4, 1);
    clear_log();
    for (int i = 0; i < W * H; i++) step(1'b1, 10, 5);
    exp8 = '{15, 15, 15, 15, 0, 0, 0, 0};
    check_list("bias_pos", 4, 1);

    // bubbles
    clear_log();
    ramp(0, 0, 1'b1);
    exp8 = '{5, 7, 13, 15, 0, 0, 0, 0};
    check_list("bubbles", 4, 1);

    // reset mid-frame
    pulse_rst();
    for (int i = 0; i < 6; i++) step(1'b1, i, 0);
    pulse_rst();
    ramp(0, 0, 1'b0);
    exp8 = '{5, 7, 13, 15, 0, 0, 0, 0};
    check_list("midreset", 4, 1);

    // back-to-back frames
    clear_log();
    ramp(0, 0, 1'b0);
    ramp(100, 0, 1'b0);
    exp8 = '{5, 7, 13, 15, 105, 107, 113, 115};
    check_list("b2b", 8, 2);

    // random frames: full-range data (wraps on bias add), random bias, random gaps
    for (int f = 0; f < 6; f++) begin
      b = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < W * H; i++) begin
        while ($urandom_range(0, 2) == 0) step(1'b0, int'($urandom), b);
        if (f < 3) step(1'b1, int'($urandom), b);
        else       step(1'b1, int'($urandom_range(0, 400)) - 200, b);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
